// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the CPU
// memory stage (master 0) and a secondary agent (master 1). Grants are
// combinational, with round-robin priority and an optional burst lock for
// master 1. Read data is routed back to its issuer through a {valid, owner}
// pipeline that matches the RAM read latency.
module dmem_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_stall,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_stall,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          ram_wren,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   input  logic [DW-1:0] ram_q
);

   typedef enum logic [1:0] {
      ST_RR0   = 2'd0,
      ST_RR1   = 2'd1,
      ST_LOCK1 = 2'd2
   } arb_state_e;

   arb_state_e        state_q, state_d;
   logic              gnt0_s, gnt1_s, prio1_s;
   logic [RD_LAT-1:0] pv_q, pv_d;   // read-return valid per stage
   logic [RD_LAT-1:0] po_q, po_d;   // read-return owner per stage (1 = m1)
   logic              exit_v_s, exit_o_s;
   logic [DW-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   // Arbitration: pick this cycle's owner and the next priority state
   always_comb begin
      gnt0_s  = 1'b0;
      gnt1_s  = 1'b0;
      prio1_s = 1'b0;
      state_d = state_q;
      if (reset) begin
         state_d = ST_RR0;
      end else if ((state_q == ST_LOCK1) && m1_req && m1_lock) begin
         // burst in progress: m1 keeps the port
         gnt1_s  = 1'b1;
         state_d = ST_LOCK1;
      end else begin
         // RR0/RR1, and the LOCK1 exit cycle which behaves as RR0
         case (state_q)
            ST_RR1:   prio1_s = 1'b1;
            ST_RR0:   prio1_s = 1'b0;
            ST_LOCK1: prio1_s = 1'b0;
            default:  prio1_s = 1'b0;
         endcase
         if (m0_req && m1_req) begin
            gnt0_s = ~prio1_s;
            gnt1_s = prio1_s;
         end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
         end
         if (gnt0_s) begin
            state_d = ST_RR1;
         end else if (gnt1_s) begin
            state_d = m1_lock ? ST_LOCK1 : ST_RR0;
         end else if (state_q == ST_LOCK1) begin
            state_d = ST_RR0;
         end else begin
            state_d = state_q;
         end
      end
   end

   // RAM pin drive from the granted master; idle bus is all zeros
   always_comb begin
      ram_wren    = 1'b0;
      ram_address = {AW{1'b0}};
      ram_data    = {DW{1'b0}};
      if (gnt0_s) begin
         ram_wren    = m0_we;
         ram_address = m0_addr;
         ram_data    = m0_wdata;
      end else if (gnt1_s) begin
         ram_wren    = m1_we;
         ram_address = m1_addr;
         ram_data    = m1_wdata;
      end else begin
         ram_wren    = 1'b0;
      end
   end

   // Read-return pipeline: granted reads enter stage 0 and shift one stage per cycle
   always_comb begin
      pv_d    = pv_q;
      po_d    = po_q;
      pv_d[0] = (gnt0_s & ~m0_we) | (gnt1_s & ~m1_we);
      po_d[0] = gnt1_s;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
      end
   end

   // Entries leaving during reset belong to reads that reset has cancelled
   assign exit_v_s = pv_q[RD_LAT-1] & ~reset;
   assign exit_o_s = po_q[RD_LAT-1];

   // Route ram_q to the owning master; the other master keeps its last data
   always_comb begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (exit_v_s && !exit_o_s) begin
         rdata0_d = ram_q;
      end else if (exit_v_s && exit_o_s) begin
         rdata1_d = ram_q;
      end else begin
         rdata0_d = rdata0_q;
         rdata1_d = rdata1_q;
      end
   end

   // State, pipeline and held read-data registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RR0;
         pv_q     <= {RD_LAT{1'b0}};
         po_q     <= {RD_LAT{1'b0}};
         rdata0_q <= {DW{1'b0}};
         rdata1_q <= {DW{1'b0}};
      end else begin
         state_q  <= state_d;
         pv_q     <= pv_d;
         po_q     <= po_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign m0_gnt    = gnt0_s;
   assign m1_gnt    = gnt1_s;
   assign m0_stall  = m0_req & ~gnt0_s & ~reset;
   assign m1_stall  = m1_req & ~gnt1_s & ~reset;
   assign m0_rvalid = exit_v_s & ~exit_o_s;
   assign m1_rvalid = exit_v_s & exit_o_s;
   assign m0_rdata  = rdata0_d;
   assign m1_rdata  = rdata1_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three DUTs (RD_LAT = 1, 2, 3) share one directed
// stimulus stream. Each has its own RAM model. Per-cycle grant and RAM-pin
// checks run in the stimulus process. Each expected read return is pushed
// into a per-DUT queue and checked by an independent monitor.
module tb_dmem_arbiter;

   typedef struct packed {
      logic        owner;
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

   logic        m0_gnt_a [1:3];
   logic        m0_stall_a [1:3];
   logic        m0_rvalid_a [1:3];
   logic [31:0] m0_rdata_a [1:3];
   logic        m1_gnt_a [1:3];
   logic        m1_stall_a [1:3];
   logic        m1_rvalid_a [1:3];
   logic [31:0] m1_rdata_a [1:3];
   logic        ram_wren_a [1:3];
   logic [31:0] ram_address_a [1:3];
   logic [31:0] ram_data_a [1:3];
   logic [31:0] ram_q_a [1:3];

   exp_t        exp_q [1:3][$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] cyc = 32'd0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [RD_LAT=%0d] cyc=%0d: got %h, want %h", nm, k, cyc, act, exp);
      end
   endtask

   for (genvar k = 1; k <= 3; k++) begin : g_lat
      logic [31:0] mem [256];
      logic [31:0] qp [3];

      dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(k)) u_dut (
         .clk(clk), .reset(reset),
         .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
         .m0_gnt(m0_gnt_a[k]), .m0_stall(m0_stall_a[k]),
         .m0_rvalid(m0_rvalid_a[k]), .m0_rdata(m0_rdata_a[k]),
         .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
         .m1_lock(m1_lock),
         .m1_gnt(m1_gnt_a[k]), .m1_stall(m1_stall_a[k]),
         .m1_rvalid(m1_rvalid_a[k]), .m1_rdata(m1_rdata_a[k]),
         .ram_wren(ram_wren_a[k]), .ram_address(ram_address_a[k]),
         .ram_data(ram_data_a[k]), .ram_q(ram_q_a[k])
      );

      assign ram_q_a[k] = qp[k-1];

      // RAM model: word per byte address [7:0], read data k cycles after address
      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
         mem[8'h10] = 32'hDEAD_BEEF;
         qp[0] <= 32'h0;
         qp[1] <= 32'h0;
         qp[2] <= 32'h0;
         forever begin
            @(posedge clk);
            qp[2] <= qp[1];
            qp[1] <= qp[0];
            qp[0] <= mem[ram_address_a[k][7:0]];
            if (ram_wren_a[k]) mem[ram_address_a[k][7:0]] = ram_data_a[k];
         end
      end

      // Monitor: every rvalid pops one expectation and checks owner, data, latency, hold
      initial begin
         exp_t        e;
         logic [31:0] last0, last1;
         last0 = 32'h0;
         last1 = 32'h0;
         forever begin
            @(negedge clk);
            if (reset) begin
               last0 = 32'h0;
               last1 = 32'h0;
            end
            if (m0_rvalid_a[k] && m1_rvalid_a[k]) begin
               cmp("rvalid_onehot", k, 32'd2, 32'd1);
            end else if (m0_rvalid_a[k] || m1_rvalid_a[k]) begin
               if (exp_q[k].size() == 0) begin
                  cmp("unexpected_rvalid", k, 32'(m1_rvalid_a[k]) + 32'd1, 32'd0);
               end else begin
                  e = exp_q[k].pop_front();
                  cmp("rv_owner", k, 32'(m1_rvalid_a[k]), 32'(e.owner));
                  cmp("rv_cycle", k, cyc, e.cyc + 32'(k));
                  if (m1_rvalid_a[k]) begin
                     cmp("m1_rdata", k, m1_rdata_a[k], e.data);
                     cmp("m0_rdata_hold", k, m0_rdata_a[k], last0);
                     last1 = e.data;
                  end else begin
                     cmp("m0_rdata", k, m0_rdata_a[k], e.data);
                     cmp("m1_rdata_hold", k, m1_rdata_a[k], last1);
                     last0 = e.data;
                  end
               end
            end
         end
      end
   end

   // One clock cycle: drive inputs after the edge, check combinational outputs
   // at the falling edge, and queue the expected read return if one is due.
   task automatic step(input logic rst,
                       input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk, input logic eg0, input logic eg1,
                       input logic [31:0] ed, input logic ret);
      logic        ewren;
      logic [31:0] eaddr, edata;
      exp_t        e;
      @(posedge clk);
      #1;
      reset = rst;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_lock = lk;
      @(negedge clk);
      ewren = (eg0 & w0) | (eg1 & w1);
      eaddr = eg0 ? a0 : (eg1 ? a1 : 32'h0);
      edata = eg0 ? d0 : (eg1 ? d1 : 32'h0);
      for (int k = 1; k <= 3; k++) begin
         cmp("m0_gnt", k, 32'(m0_gnt_a[k]), 32'(eg0));
         cmp("m1_gnt", k, 32'(m1_gnt_a[k]), 32'(eg1));
         cmp("m0_stall", k, 32'(m0_stall_a[k]), 32'(r0 & ~eg0 & ~rst));
         cmp("m1_stall", k, 32'(m1_stall_a[k]), 32'(r1 & ~eg1 & ~rst));
         cmp("ram_wren", k, 32'(ram_wren_a[k]), 32'(ewren));
         cmp("ram_address", k, ram_address_a[k], eaddr);
         cmp("ram_data", k, ram_data_a[k], edata);
         if (ret && ((eg0 && !w0) || (eg1 && !w1))) begin
            e.owner = eg1;
            e.data  = ed;
            e.cyc   = cyc;
            exp_q[k].push_back(e);
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic chk_rdata_zero();
      for (int k = 1; k <= 3; k++) begin
         cmp("m0_rdata_reset", k, m0_rdata_a[k], 32'h0);
         cmp("m1_rdata_reset", k, m1_rdata_a[k], 32'h0);
      end
   endtask

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_lock = 1'b0;

      // reset gates grants, stalls and writes even with requests present
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      idle();
      chk_rdata_zero();

      // single m0 read of 0x10 (RR0 -> RR1)
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
      idle();

      // m1 alone (RR1 -> RR0), then both request for 4 cycles: m0,m1,m0,m1
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_0014, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000_0040, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_0044, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000_0048, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_004C, 1'b1);

      // m0 alone (RR0 -> RR1), then locked m1 burst writes 0x20 while m0 waits
      step(1'b0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000_0018, 1'b1);
      for (int n = 0; n < 3; n++) begin
         step(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
      end
      // lock drops: exit cycle uses RR0 rules, so m0 wins
      step(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h1000_0060, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);

      // m0 read (RR0 -> RR1), then m0 write 0x30 collides with m1 read: m1 first
      step(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h30, 32'hA1B2_C3D4, 1'b1, 1'b0, 32'h1C, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_001C, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h30, 32'hA1B2_C3D4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA1B2_C3D4, 1'b1);

      // back-to-back reads m0, m1, m0: returns in order, one per cycle
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
      for (int n = 0; n < 6; n++) idle();

      // granted read then reset: the read never returns; state back to RR0
      step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      idle();
      chk_rdata_zero();
      step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1000_0014, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1000_0018, 1'b1);
      for (int n = 0; n < 6; n++) idle();

      // every queued read must have come back
      for (int k = 1; k <= 3; k++) cmp("pending_reads", k, 32'(exp_q[k].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters on a per-cycle basis:
  - master 0: the CPU memory stage;
  - master 1: a secondary agent, such as a program/data loader or a display read-out.
- Sits between the cpu data port and the RAM instance in the top level; drives the RAM's wren/address/data pins.
- Returns read data to the owning master with a valid strobe.
- Produces a stall for the CPU whenever it loses arbitration.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in cycles from address sample to q valid (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU access request (read or write) this cycle.
- m0_we  in  1  CPU write enable (meaningful when m0_req=1).
- m0_addr  in  AW  CPU byte address.
- m0_wdata  in  DW  CPU write data.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_stall  out  1  m0_req & ~m0_gnt; freezes the CPU pipeline.
- m0_rvalid  out  1  read data for a granted m0 read is present on m0_rdata.
- m0_rdata  out  DW  read data to the CPU.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0 for master 1.
- m1_lock  in  1  while high with m1_req, master 1 keeps ownership after its first grant (burst).
- ram_wren  out  1  RAM write enable.
- ram_address  out  AW  RAM address.
- ram_data  out  DW  RAM write data.
- ram_q  in  DW  RAM read data, valid RD_LAT cycles after address.

Behaviour:
- Grant is combinational from the current requests plus registered state. The RAM samples ram_* at the next rising edge; one access per cycle.
- Arbitration states (registered): RR0 (m0 has priority), RR1 (m1 has priority), LOCK1 (m1 owns the port).
- In RR0/RR1:
  - Only one master requests: that master is granted.
  - Both request: the priority master is granted.
  - The next state after a grant gives priority to the *other* master (round-robin).
  - No request: the state is unchanged.
- Entering and staying in LOCK1:
  - A grant to m1 with m1_lock=1 enters LOCK1.
  - LOCK1 grants m1 every cycle that m1_req=1; m0 is never granted, so m0_stall follows m0_req.
  - LOCK1 exits to RR0 when m1_req=0 or m1_lock=0. The exit cycle itself follows the RR0 rules.
- RAM drive: ram_address/ram_data/ram_wren come from the granted master; ram_wren = granted & we. With no grant: ram_wren=0, address/data=0.
- Read return: a shift pipeline of depth RD_LAT carries {valid, owner} for each granted read.
  - At pipeline exit, the owner's rvalid=1 and its rdata=ram_q.
  - The non-owner's rdata holds its last value.
  - Writes enter no pipeline entry and never produce rvalid.
- Back-to-back reads from alternating masters are returned in issue order with no bubbles.
- Reset (sync, active-high):
  - state=RR0; read pipeline cleared; m0_rdata=m1_rdata=0; rvalid=0.
  - gnt, stall and ram_wren are 0 during the reset cycle regardless of requests.
- Reset mid-operation drops in-flight reads: no rvalid appears after reset deasserts for reads issued before it.
- Requests with a write and m_req=0 are ignored. m_we, addr and wdata are don't-care when req=0.
- Every cycle: m0_gnt & m1_gnt = 0, and at most one rvalid is asserted.

Test Plan:
- Reset, then m0 alone reads 0x10 with RAM holding 0xDEADBEEF at 0x10 (RD_LAT=1): m0_gnt=1 same cycle, m0_stall=0; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Both request continuously for 4 cycles from RR0: grants go m0,m1,m0,m1; m0_stall=1 in cycles 2 and 4; rvalid owners alternate one cycle later.
- m1 writes 0x20=0x12345678 with m1_lock=1 for 3 cycles while m0 requests: m1_gnt=1 for 3 cycles, m0_stall=1 throughout, ram_wren=1 each cycle. On the 4th cycle lock drops: m0 granted.
- m0 write to 0x30 colliding with an m1 read, priority RR1: m1 granted; m0 granted next cycle with ram_wren=1, ram_address=0x30; no rvalid generated for the write.
- RD_LAT=3: reads issued m0,m1,m0 in consecutive cycles → rvalid at cycles +3,+4,+5 with owners m0,m1,m0 and the matching ram_q values.
- Reset asserted one cycle after a granted read (RD_LAT=2): no m0_rvalid appears; rdata=0; state=RR0; a subsequent both-request grants m0 first.
